// File: rtl/motor_drive_ctrl.sv
// Line-tracker motor drive: debounces the 2-bit position code and runs the drive/search FSM.
// Generates slew-limited PWM duty plus H-bridge direction pins for both wheels.
`timescale 1ns/1ps
module motor_drive_ctrl #(
    parameter int PWM_PERIOD   = 1024,
    parameter int DUTY_FAST    = 1000,
    parameter int DUTY_SLOW    = 600,
    parameter int RAMP_STEP    = 64,
    parameter int DEBOUNCE     = 4,
    parameter int LOST_TIMEOUT = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    input  logic       enable,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic [1:0] left_dir,
    output logic [1:0] right_dir,
    output logic [2:0] mode
);
    localparam int CW = $clog2(PWM_PERIOD + 1);
    localparam int LW = $clog2(LOST_TIMEOUT + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(PWM_PERIOD - 1);
    localparam logic [CW-1:0] D_FAST   = CW'(DUTY_FAST);
    localparam logic [CW-1:0] D_SLOW   = CW'(DUTY_SLOW);
    localparam logic [CW-1:0] STEP     = CW'(RAMP_STEP);
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE);
    localparam logic [LW-1:0] LOST_MAX = LW'(LOST_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STOP   = 3'd1;
    localparam logic [2:0] S_FWD    = 3'd2;
    localparam logic [2:0] S_LEFT   = 3'd3;
    localparam logic [2:0] S_RIGHT  = 3'd4;
    localparam logic [2:0] S_SEARCH = 3'd5;

    localparam logic [1:0] DIR_FWD   = 2'b10;
    localparam logic [1:0] DIR_COAST = 2'b00;

    logic [1:0]    cand_q, cand_d, cmd_q, cmd_d;
    logic [DW-1:0] dbc_q, dbc_d;
    logic [2:0]    mode_q, mode_d;
    logic [LW-1:0] lost_q, lost_d;
    logic [CW-1:0] tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
    logic [CW-1:0] cnt_q, cnt_d, duty_l_q, duty_l_d, duty_r_q, duty_r_d;
    logic          pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
    logic [1:0]    dir_l_q, dir_l_d, dir_r_q, dir_r_d;

    function automatic logic [2:0] cmd_state(input logic [1:0] c);
        case (c)
            2'b11:   cmd_state = S_FWD;
            2'b01:   cmd_state = S_LEFT;
            2'b10:   cmd_state = S_RIGHT;
            default: cmd_state = S_STOP;
        endcase
    endfunction

    // Step toward the target without overshooting; cur+STEP cannot exceed tgt here.
    function automatic logic [CW-1:0] ramp(input logic [CW-1:0] cur, input logic [CW-1:0] tgt);
        if (cur < tgt) begin
            ramp = ((tgt - cur) > STEP) ? cur + STEP : tgt;
        end else if (cur > tgt) begin
            ramp = ((cur - tgt) > STEP) ? cur - STEP : tgt;
        end else begin
            ramp = cur;
        end
    endfunction

    function automatic logic [1:0] side_dir(input logic [2:0] m, input logic [CW-1:0] duty);
        if (m == S_IDLE) begin
            side_dir = DIR_COAST;
        end else if ((m != S_STOP) || (duty != {CW{1'b0}})) begin
            side_dir = DIR_FWD;
        end else begin
            side_dir = DIR_COAST;
        end
    endfunction

    // Code debounce: cmd follows only after DEBOUNCE identical consecutive samples.
    always_comb begin
        cand_d = cand_q;
        dbc_d  = dbc_q;
        cmd_d  = cmd_q;
        if (state != cand_q) begin
            cand_d = state;
            dbc_d  = DW'(1);
            if (DEBOUNCE == 1) begin
                cmd_d = state;
            end else begin
                cmd_d = cmd_q;
            end
        end else begin
            dbc_d = (dbc_q != DB_MAX) ? dbc_q + DW'(1) : dbc_q;
            if (dbc_d == DB_MAX) begin
                cmd_d = cand_q;
            end else begin
                cmd_d = cmd_q;
            end
        end
    end

    // Drive FSM, lost-line timer and per-wheel duty targets.
    always_comb begin
        mode_d  = mode_q;
        lost_d  = lost_q;
        tgt_l_d = tgt_l_q;
        tgt_r_d = tgt_r_q;
        if (!enable) begin
            mode_d = S_IDLE;
        end else begin
            case (mode_q)
                S_IDLE: mode_d = S_STOP;
                S_STOP: mode_d = cmd_state(cmd_q);
                S_FWD, S_LEFT, S_RIGHT: begin
                    if (cmd_q == 2'b00) begin
                        mode_d = S_SEARCH;
                        lost_d = {LW{1'b0}};
                    end else begin
                        mode_d = cmd_state(cmd_q);
                    end
                end
                S_SEARCH: begin
                    if (cmd_q != 2'b00) begin
                        mode_d = cmd_state(cmd_q);
                        lost_d = {LW{1'b0}};
                    end else if (lost_q == LOST_MAX) begin
                        mode_d = S_STOP;
                    end else begin
                        lost_d = lost_q + LW'(1);
                    end
                end
                default: mode_d = S_IDLE;
            endcase
        end
        // SEARCH keeps whatever the wheels were last aiming for.
        case (mode_d)
            S_FWD:    begin tgt_l_d = D_FAST; tgt_r_d = D_FAST; end
            S_LEFT:   begin tgt_l_d = D_SLOW; tgt_r_d = D_FAST; end
            S_RIGHT:  begin tgt_l_d = D_FAST; tgt_r_d = D_SLOW; end
            S_SEARCH: begin tgt_l_d = tgt_l_q; tgt_r_d = tgt_r_q; end
            default:  begin tgt_l_d = {CW{1'b0}}; tgt_r_d = {CW{1'b0}}; end
        endcase
    end

    // PWM counter, period-boundary duty ramp and output pin decode.
    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? {CW{1'b0}} : cnt_q + CW'(1);
        if (mode_d == S_IDLE) begin
            duty_l_d = {CW{1'b0}};
            duty_r_d = {CW{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            duty_l_d = ramp(duty_l_q, tgt_l_q);
            duty_r_d = ramp(duty_r_q, tgt_r_q);
        end else begin
            duty_l_d = duty_l_q;
            duty_r_d = duty_r_q;
        end
        pwm_l_d = (mode_d != S_IDLE) && (cnt_q < duty_l_q);
        pwm_r_d = (mode_d != S_IDLE) && (cnt_q < duty_r_q);
        dir_l_d = side_dir(mode_d, duty_l_d);
        dir_r_d = side_dir(mode_d, duty_r_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_q   <= 2'b00;
            dbc_q    <= {DW{1'b0}};
            cmd_q    <= 2'b00;
            mode_q   <= S_IDLE;
            lost_q   <= {LW{1'b0}};
            tgt_l_q  <= {CW{1'b0}};
            tgt_r_q  <= {CW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            duty_l_q <= {CW{1'b0}};
            duty_r_q <= {CW{1'b0}};
            pwm_l_q  <= 1'b0;
            pwm_r_q  <= 1'b0;
            dir_l_q  <= DIR_COAST;
            dir_r_q  <= DIR_COAST;
        end else begin
            cand_q   <= cand_d;
            dbc_q    <= dbc_d;
            cmd_q    <= cmd_d;
            mode_q   <= mode_d;
            lost_q   <= lost_d;
            tgt_l_q  <= tgt_l_d;
            tgt_r_q  <= tgt_r_d;
            cnt_q    <= cnt_d;
            duty_l_q <= duty_l_d;
            duty_r_q <= duty_r_d;
            pwm_l_q  <= pwm_l_d;
            pwm_r_q  <= pwm_r_d;
            dir_l_q  <= dir_l_d;
            dir_r_q  <= dir_r_d;
        end
    end

    assign left_pwm  = pwm_l_q;
    assign right_pwm = pwm_r_q;
    assign left_dir  = dir_l_q;
    assign right_dir = dir_r_q;
    assign mode      = mode_q;
endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Directed bench for motor_drive_ctrl with a 16-cycle PWM period and 100-cycle lost timeout.
`timescale 1ns/1ps
module tb_motor_drive_ctrl;
    logic       clk;
    logic       reset;
    logic [1:0] state;
    logic       enable;
    logic       left_pwm, right_pwm;
    logic [1:0] left_dir, right_dir;
    logic [2:0] mode;

    int n_checks = 0;
    int n_fails  = 0;
    int hi;

    motor_drive_ctrl #(
        .PWM_PERIOD(16), .DUTY_FAST(12), .DUTY_SLOW(6),
        .RAMP_STEP(4), .DEBOUNCE(4), .LOST_TIMEOUT(100)
    ) dut (
        .clk(clk), .reset(reset), .state(state), .enable(enable),
        .left_pwm(left_pwm), .right_pwm(right_pwm),
        .left_dir(left_dir), .right_dir(right_dir), .mode(mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; state = 2'b00;
        step(3);
        chk("rst_mode", 16'(mode), 16'd0);
        chk("rst_lpwm", 16'(left_pwm), 16'd0);
        chk("rst_rpwm", 16'(right_pwm), 16'd0);
        chk("rst_ldir", 16'(left_dir), 16'd0);
        chk("rst_rdir", 16'(right_dir), 16'd0);
        chk("rst_duty", 16'(dut.duty_l_q), 16'd0);
        chk("rst_cmd", 16'(dut.cmd_q), 16'd0);

        // 1: start-up, debounce latency and ramp to full speed
        reset = 1'b1; enable = 1'b1; state = 2'b11;
        step(1);  chk("t1_stop", 16'(mode), 16'd1);
        step(3);  chk("t1_cmd", 16'(dut.cmd_q), 16'd3);
                  chk("t1_still_stop", 16'(mode), 16'd1);
        step(1);  chk("t1_fwd", 16'(mode), 16'd2);
        step(11); chk("t1_duty4", 16'(dut.duty_l_q), 16'd4);
        step(16); chk("t1_duty8", 16'(dut.duty_l_q), 16'd8);
        step(16); chk("t1_duty12", 16'(dut.duty_l_q), 16'd12);
                  chk("t1_rduty12", 16'(dut.duty_r_q), 16'd12);
                  chk("t1_ldir", 16'(left_dir), 16'd2);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            hi += int'(left_pwm);
        end
        chk("t1_pwm_high", 16'(hi), 16'd12);

        // 2: three-cycle glitch is ignored, four-cycle code is accepted
        state = 2'b01; step(3); state = 2'b11; step(5);
        chk("t2_glitch_mode", 16'(mode), 16'd2);
        chk("t2_glitch_cmd", 16'(dut.cmd_q), 16'd3);
        state = 2'b01; step(5);
        chk("t2_left", 16'(mode), 16'd3);
        step(3);  chk("t2_lduty8", 16'(dut.duty_l_q), 16'd8);
                  chk("t2_rduty12a", 16'(dut.duty_r_q), 16'd12);
        step(16); chk("t2_lduty6", 16'(dut.duty_l_q), 16'd6);
                  chk("t2_rduty12b", 16'(dut.duty_r_q), 16'd12);

        // 3: line lost, search timeout, ramp-down and coast
        state = 2'b11; step(32);
        chk("t3_fwd", 16'(mode), 16'd2);
        chk("t3_duty12", 16'(dut.duty_l_q), 16'd12);
        state = 2'b00; step(5);
        chk("t3_search", 16'(mode), 16'd5);
        step(99); chk("t3_search_end", 16'(mode), 16'd5);
                  chk("t3_hold_l", 16'(dut.duty_l_q), 16'd12);
                  chk("t3_hold_r", 16'(dut.duty_r_q), 16'd12);
        step(1);  chk("t3_timeout_stop", 16'(mode), 16'd1);
        step(7);  chk("t3_duty8", 16'(dut.duty_l_q), 16'd8);
        step(16); chk("t3_duty4", 16'(dut.duty_l_q), 16'd4);
                  chk("t3_dir_still_fwd", 16'(left_dir), 16'd2);
        step(16); chk("t3_duty0_l", 16'(dut.duty_l_q), 16'd0);
                  chk("t3_duty0_r", 16'(dut.duty_r_q), 16'd0);
                  chk("t3_ldir_coast", 16'(left_dir), 16'd0);
                  chk("t3_rdir_coast", 16'(right_dir), 16'd0);

        // 4: line recovered mid-search goes straight to RIGHT
        state = 2'b11; step(5);
        chk("t4_fwd", 16'(mode), 16'd2);
        state = 2'b00; step(5);
        chk("t4_search", 16'(mode), 16'd5);
        step(50); state = 2'b10; step(4);
        chk("t4_no_stop", 16'(mode), 16'd5);
        step(1);  chk("t4_right", 16'(mode), 16'd4);
        step(15); chk("t4_rduty8", 16'(dut.duty_r_q), 16'd8);
                  chk("t4_lduty12", 16'(dut.duty_l_q), 16'd12);
        step(16); chk("t4_rduty6", 16'(dut.duty_r_q), 16'd6);

        // 5: enable drop forces IDLE and zero duty on the next edge
        state = 2'b11; step(32);
        chk("t5_fwd", 16'(mode), 16'd2);
        chk("t5_rduty12", 16'(dut.duty_r_q), 16'd12);
        enable = 1'b0; step(1);
        chk("t5_idle", 16'(mode), 16'd0);
        chk("t5_duty0", 16'(dut.duty_l_q), 16'd0);
        chk("t5_lpwm", 16'(left_pwm), 16'd0);
        chk("t5_ldir", 16'(left_dir), 16'd0);
        chk("t5_rdir", 16'(right_dir), 16'd0);

        // 6: asynchronous reset in the middle of a ramp
        enable = 1'b1; step(31);
        chk("t6_duty8", 16'(dut.duty_l_q), 16'd8);
        step(2);  chk("t6_pwm_high", 16'(left_pwm), 16'd1);
        #2 reset = 1'b0;
        #1;
        chk("t6_lpwm", 16'(left_pwm), 16'd0);
        chk("t6_mode", 16'(mode), 16'd0);
        chk("t6_duty", 16'(dut.duty_l_q), 16'd0);
        chk("t6_cmd", 16'(dut.cmd_q), 16'd0);
        chk("t6_ldir", 16'(left_dir), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
